// File: rtl/prbs_if.sv
// Bit-stream and status bundle between a PRBS source/monitor and the checker.
interface prbs_if #(
  parameter int NBITS = 8,
  parameter int ERR_W = 16
) ();
  logic             en;
  logic             din;
  logic [NBITS-1:0] tap;
  logic             clr;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, din, tap, clr,
    input  locked, err, err_cnt
  );

  modport slave (
    input  en, din, tap, clr,
    output locked, err, err_cnt
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills a history window from the line, hunts for
// a run of predicted bits, then free-runs the reference and counts bit errors.
//
// state  | meaning
// FILL   | loading NBITS received bits into the history, no comparison
// HUNT   | history fed from line; counting consecutive correct predictions
// LOCKED | history free-runs on its own prediction; line bits are checked
module prbs_checker #(
  parameter int NBITS       = 8,
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input logic   clk,
  input logic   rst,
  prbs_if.slave bus
);
  localparam int FILL_W  = $clog2(NBITS + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W   = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic               rst_meta, rst_sync;
  logic [NBITS-1:0]   h;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MATCH_W-1:0] good_run;
  logic [BAD_W-1:0]   bad_cnt;
  logic [ERR_W-1:0]   err_cnt;
  logic               err_q, locked_q;
  logic               err_d, locked_d;
  logic               exp_bit, new_bit, hit, h_zero;
  logic               fill_last, lock_reached, unlock_now, good_full;
  logic               unused_tap0;

  assign unused_tap0 = bus.tap[0];

  // Reset asserts at once but releases on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  always_comb begin
    exp_bit      = h[0] ^ (^(h[NBITS-1:1] & bus.tap[NBITS-1:1]));
    h_zero       = (h == '0);
    hit          = (bus.din == exp_bit);
    fill_last    = (fill_cnt == FILL_W'(NBITS - 1));
    lock_reached = hit && !h_zero && (match_cnt == MATCH_W'(LOCK_CNT - 1));
    unlock_now   = !hit && (bad_cnt == BAD_W'(UNLOCK_ERRS - 1));
    good_full    = (good_run == MATCH_W'(LOCK_CNT - 1));
    new_bit      = (state == LOCKED) ? exp_bit : bus.din;
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) state <= FILL;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.en) begin
      case (state)
        FILL:    if (fill_last)    state_nx = HUNT;
        HUNT:    if (lock_reached) state_nx = LOCKED;
        LOCKED:  if (unlock_now)   state_nx = FILL;
        default:                   state_nx = FILL;
      endcase
    end
  end

  always_comb begin
    err_d    = bus.en && (state == LOCKED) && !hit;
    locked_d = (state_nx == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      h         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      good_run  <= '0;
      bad_cnt   <= '0;
    end else if (bus.en) begin
      h <= {new_bit, h[NBITS-1:1]};
      case (state)
        FILL: begin
          fill_cnt  <= fill_last ? '0 : fill_cnt + 1'b1;
          match_cnt <= '0;
        end
        HUNT: begin
          if (hit && !h_zero) match_cnt <= lock_reached ? '0 : match_cnt + 1'b1;
          else                match_cnt <= '0;
          if (lock_reached) begin
            bad_cnt  <= '0;
            good_run <= '0;
          end
        end
        LOCKED: begin
          if (!hit) begin
            good_run <= '0;
            bad_cnt  <= unlock_now ? '0 : bad_cnt + 1'b1;
            if (unlock_now) fill_cnt <= '0;
          end else if (good_full) begin
            good_run <= '0;
            bad_cnt  <= '0;
          end else begin
            good_run <= good_run + 1'b1;
          end
        end
        default: fill_cnt <= '0;
      endcase
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync)                       err_cnt <= '0;
    else if (bus.clr)                    err_cnt <= '0;
    else if (err_d && (err_cnt != '1))   err_cnt <= err_cnt + 1'b1;
  end

  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt;
endmodule
